nyq_par_loader: RTL and testbench
=================================

# nyq_par_loader

Coefficient/parameter write initiator for the NYQ filter block. Accepts a byte stream over a valid/ready handshake, assembles little-endian MEM_WIDTH-bit words, and drives the NYQ parameter write port (WrEn/Addr/PAR_In) to consecutive addresses 0..NUM_WORDS-1. It sits between the host/configuration interface and the NYQ block, and replaces direct testbench driving of the parameter port in the integrated design.

## Interface
- ADDR_WIDTH, 5, width of the NYQ parameter address
- MEM_WIDTH, 32, parameter word width; must be a multiple of 8 (BPW = MEM_WIDTH/8 bytes per word)
- NUM_WORDS, 32, words per load sequence; 1 ≤ NUM_WORDS ≤ 2^ADDR_WIDTH

Ports:
- Clk_CI  in  1  single clock; all logic on the rising edge
- Rst_RBI  in  1  reset, asynchronous, active-low
- Start_SI  in  1  start request, sampled only in IDLE
- ByteValid_SI  in  1  input byte valid
- ByteReady_SO  out  1  loader can accept a byte
- Byte_DI  in  8  input byte
- WrEn_SO  out  1  parameter write enable to NYQ WrEn_SI
- Addr_DO  out  ADDR_WIDTH  parameter address to NYQ Addr_DI
- PAR_Out_DO  out  MEM_WIDTH  parameter word to NYQ PAR_In_DI
- Busy_SO  out  1  high in every state except IDLE
- Done_SO  out  1  one-cycle pulse at sequence end
- Err_SO  out  1  checksum mismatch, sticky until next accepted Start

## Operation
- All outputs registered. Reset value of every output: 0. State after reset: IDLE.
- Byte handshake: a byte is accepted in a cycle when ByteValid_SI & ByteReady_SO. Byte_DI must be stable while valid is high and ready is low. The loader never drops a valid byte.
- States:
  - IDLE: ByteReady_SO=0. Start_SI=1 → COLLECT. Clear byte count, address, checksum, and Err_SO.
  - COLLECT: ByteReady_SO=1. Byte k of a word (k=0..BPW-1) is placed in bits [8k+7:8k]. When byte BPW-1 is accepted, ByteReady_SO=0 next cycle → WRITE.
  - WRITE (1 cycle): WrEn_SO=1, Addr_DO=current address, PAR_Out_DO=assembled word. If address==NUM_WORDS-1, go to CHECK (macro defined) or DONE. Otherwise increment the address and go to COLLECT.
  - CHECK (macro only): ByteReady_SO=1. Accept one byte and compare it with the running checksum → DONE.
  - DONE (1 cycle): Done_SO=1 → IDLE.
- Addr_DO and PAR_Out_DO hold their last written values outside WRITE. WrEn_SO is high only in WRITE.
- Start_SI outside IDLE is ignored; no queuing.
- Reset mid-sequence returns the loader to IDLE immediately with all outputs at 0. Words already written to NYQ are not rolled back. The next Start restarts at address 0.
- Address never wraps: the sequence ends at NUM_WORDS-1.

## Timing
- If Start_SI is sampled high at edge t, the loader is in COLLECT from cycle t+1.
- With continuous valid, each word takes BPW accept cycles plus 1 WRITE cycle. Word n is written at cycle t+(n+1)(BPW+1).
- Last write occurs at t+NUM_WORDS(BPW+1). Done_SO follows 1 cycle later without the macro, or 2 cycles later with it (the checksum byte arrives with no gap).
- Valid gaps stretch COLLECT/CHECK cycle-for-cycle. No other latency changes.
- Err_SO updates in the same cycle that Done_SO rises.

## Configuration
- NYQ_PAR_CHECKSUM_EN defined:
  - Adds the CHECK state.
  - Checksum = 8-bit sum (mod 256) of all data bytes of the sequence.
  - A mismatching trailing byte sets Err_SO=1.
  - The parameter writes still occur; the loader does not gate them.
- NYQ_PAR_CHECKSUM_EN not defined:
  - No CHECK state; WRITE of the last word → DONE.
  - Err_SO is tied 0.
  - No trailing byte is consumed.

## Test plan
All scenarios use the default parameters (BPW=4, NUM_WORDS=32); Start_SI is sampled at edge t.
- Reset: hold Rst_RBI=0 with random inputs → all outputs 0, Busy_SO=0. Release → still IDLE.
- Continuous load, no macro: stream bytes 0x00..0x7F → writes addr 0 = 0x03020100 at t+5, addr 31 = 0x7F7E7D7C at t+160, Done_SO at t+161. Exactly 32 WrEn pulses.
- Throttled source: ByteValid_SI high every other cycle → same 32 address/data pairs. WrEn_SO only after each 4th accepted byte. ByteReady_SO=0 during WRITE.
- Start while busy: pulse Start_SI at the addr 5 write and again in DONE → no restart, sequence completes normally.
- Reset mid-sequence: assert Rst_RBI after the addr 10 write → outputs 0 asynchronously. A new Start with bytes 0xAA.. → first write is to addr 0.
- Checksum (macro defined): bytes 0x00..0x7F then 0xC0 → Err_SO=0, Done_SO at t+162. Repeat with 0xC1 → Err_SO=1 and held until next Start.

Source files
------------

// File: rtl/nyq_par_loader.sv
// nyq_par_loader: byte-stream to NYQ parameter-port write initiator.
// Accepts bytes over a valid/ready handshake, packs them little-endian into
// MEM_WIDTH-bit words and writes them to addresses 0..NUM_WORDS-1.
// Optional feature macro: NYQ_PAR_CHECKSUM_EN adds a trailing 8-bit checksum
// byte (sum mod 256 of all data bytes); a mismatch raises the sticky Err_SO.
module nyq_par_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_WIDTH  = 32,
  parameter int NUM_WORDS  = 32
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  Start_SI,
  input  logic                  ByteValid_SI,
  output logic                  ByteReady_SO,
  input  logic [7:0]            Byte_DI,
  output logic                  WrEn_SO,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  output logic [MEM_WIDTH-1:0]  PAR_Out_DO,
  output logic                  Busy_SO,
  output logic                  Done_SO,
  output logic                  Err_SO
);

  localparam int BPW   = MEM_WIDTH / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BPW - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DONE    = 3'd3
`ifdef NYQ_PAR_CHECKSUM_EN
    , ST_CHECK = 3'd4
`endif
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [MEM_WIDTH-1:0]    word_q;
  logic [MEM_WIDTH-1:0]    word_d;
  logic                    ready_q;
  logic                    wr_en_q;
  logic [ADDR_WIDTH-1:0]   addr_out_q;
  logic [MEM_WIDTH-1:0]    par_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    accept;

  assign accept = ByteValid_SI & ready_q;

  // Word being assembled with the incoming byte dropped into its lane.
  always_comb begin
    word_d = word_q;
    word_d[8*cnt_q +: 8] = Byte_DI;
  end

`ifdef NYQ_PAR_CHECKSUM_EN
  logic [7:0] csum_q;
  logic [7:0] csum_d;
  logic       err_q;

  // Running mod-256 sum including the byte currently offered.
  always_comb begin
    csum_d = csum_q + Byte_DI;
  end
`endif

  // Sequencer: state, byte/address counters and all registered outputs.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      ready_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_out_q <= '0;
      par_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef NYQ_PAR_CHECKSUM_EN
      csum_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start_SI) begin
            state_q <= ST_COLLECT;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            addr_q  <= '0;
`ifdef NYQ_PAR_CHECKSUM_EN
            csum_q  <= '0;
            err_q   <= 1'b0;
`endif
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            word_q <= word_d;
`ifdef NYQ_PAR_CHECKSUM_EN
            csum_q <= csum_d;
`endif
            if (cnt_q == LAST_BYTE) begin
              // Last byte of the word: present it on the write port next cycle.
              cnt_q      <= '0;
              ready_q    <= 1'b0;
              state_q    <= ST_WRITE;
              wr_en_q    <= 1'b1;
              addr_out_q <= addr_q;
              par_q      <= word_d;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_WRITE: begin
          if (addr_q == LAST_ADDR) begin
`ifdef NYQ_PAR_CHECKSUM_EN
            state_q <= ST_CHECK;
            ready_q <= 1'b1;
`else
            state_q <= ST_DONE;
            done_q  <= 1'b1;
`endif
          end else begin
            addr_q  <= addr_q + ADDR_WIDTH'(1);
            state_q <= ST_COLLECT;
            ready_q <= 1'b1;
          end
        end
`ifdef NYQ_PAR_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            err_q   <= (Byte_DI != csum_q);
            ready_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ByteReady_SO = ready_q;
  assign WrEn_SO      = wr_en_q;
  assign Addr_DO      = addr_out_q;
  assign PAR_Out_DO   = par_q;
  assign Busy_SO      = busy_q;
  assign Done_SO      = done_q;
`ifdef NYQ_PAR_CHECKSUM_EN
  assign Err_SO       = err_q;
`else
  assign Err_SO       = 1'b0;
`endif

endmodule

// File: tb/tb_nyq_par_loader.sv
// Self-checking bench for nyq_par_loader (default parameters).
// Honours NYQ_PAR_CHECKSUM_EN when the design is built with it.
`timescale 1ns/1ps
module tb_nyq_par_loader;

  localparam int ADDR_WIDTH = 5;
  localparam int MEM_WIDTH  = 32;
  localparam int NUM_WORDS  = 32;
  localparam int BPW        = MEM_WIDTH / 8;
  localparam int NDATA      = NUM_WORDS * BPW;
`ifdef NYQ_PAR_CHECKSUM_EN
  localparam int CKS = 1;
`else
  localparam int CKS = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  bvalid = 1'b0;
  logic [7:0]            bdata = 8'h00;
  logic                  ByteReady_SO;
  logic                  WrEn_SO;
  logic [ADDR_WIDTH-1:0] Addr_DO;
  logic [MEM_WIDTH-1:0]  PAR_Out_DO;
  logic                  Busy_SO;
  logic                  Done_SO;
  logic                  Err_SO;

  logic [7:0] byte_mem [NDATA];
  logic [7:0] chk_byte;
  int n_cmp = 0;
  int n_err = 0;
  bit ab;

  nyq_par_loader #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_WIDTH (MEM_WIDTH),
    .NUM_WORDS (NUM_WORDS)
  ) dut (
    .Clk_CI      (clk),
    .Rst_RBI     (rst_n),
    .Start_SI    (start),
    .ByteValid_SI(bvalid),
    .ByteReady_SO(ByteReady_SO),
    .Byte_DI     (bdata),
    .WrEn_SO     (WrEn_SO),
    .Addr_DO     (Addr_DO),
    .PAR_Out_DO  (PAR_Out_DO),
    .Busy_SO     (Busy_SO),
    .Done_SO     (Done_SO),
    .Err_SO      (Err_SO)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference word n: little-endian packing of bytes BPW*n .. BPW*n+BPW-1.
  function automatic logic [31:0] word_of(input int n);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < BPW; k++)
      w = w + ({24'd0, byte_mem[(n * BPW + k) % NDATA]} << (8 * k));
    return w;
  endfunction

  function automatic logic [7:0] sum_bytes();
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < NDATA; i++) s = s + byte_mem[i];
    return s;
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({WrEn_SO, Busy_SO, Done_SO, Err_SO, ByteReady_SO, Addr_DO, PAR_Out_DO});
  endfunction

  // vmode: 0 continuous, 1 every other cycle, 2 random gaps.
  // poke: pulse Start at the addr-5 write and in DONE. abort_addr: reset after that write.
  task automatic load_seq(input int vmode, input bit poke, input int abort_addr, output bit aborted);
    int cyc, bi, nwr, last_acc;
    bit acc, done_seen;
    logic err_exp;
    err_exp = 1'b0;
`ifdef NYQ_PAR_CHECKSUM_EN
    err_exp = (chk_byte != sum_bytes());
`endif
    aborted = 1'b0;
    start = 1'b1;
    bvalid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; bi = 0; nwr = 0; last_acc = -1; done_seen = 1'b0;
    check_eq("start_busy", 64'(Busy_SO), 64'd1);
    check_eq("start_ready", 64'(ByteReady_SO), 64'd1);
    check_eq("start_err_clr", 64'(Err_SO), 64'd0);
    while (!done_seen && cyc < 3000) begin
      if (bi < NDATA + CKS) begin
        case (vmode)
          0:       bvalid = 1'b1;
          1:       bvalid = ((cyc % 2) == 0);
          default: bvalid = ($urandom_range(0, 2) != 0);
        endcase
        bdata = (bi < NDATA) ? byte_mem[bi] : chk_byte;
      end else begin
        // A stray byte offered after the sequence must never be taken.
        bvalid = 1'b1;
        bdata = 8'h5A;
      end
      start = poke && WrEn_SO && (Addr_DO == 5'd5);
      acc = bvalid && ByteReady_SO;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        bi++;
        last_acc = cyc;
      end
      if (WrEn_SO) begin
        check_eq("wr_addr", 64'(Addr_DO), 64'(nwr));
        check_eq("wr_data", 64'(PAR_Out_DO), 64'(word_of(nwr)));
        check_eq("wr_ready_low", 64'(ByteReady_SO), 64'd0);
        check_eq("wr_after_4th", 64'(bi), 64'((nwr + 1) * BPW));
        check_eq("wr_latency", 64'(cyc), 64'(last_acc));
        if (vmode == 0) check_eq("wr_cycle", 64'(cyc), 64'((nwr + 1) * (BPW + 1) - 1));
        nwr++;
        if (nwr == abort_addr + 1) begin
          rst_n = 1'b0;
          #1;
          check_eq("abort_outs_zero", all_outs(), 64'd0);
          aborted = 1'b1;
          bvalid = 1'b0;
          start = 1'b0;
          return;
        end
      end
      check_eq("busy_in_seq", 64'(Busy_SO), 64'd1);
      if (Done_SO) begin
        done_seen = 1'b1;
        check_eq("done_nwr", 64'(nwr), 64'(NUM_WORDS));
        check_eq("done_bytes", 64'(bi), 64'(NDATA + CKS));
        check_eq("err_at_done", 64'(Err_SO), 64'(err_exp));
        if (vmode == 0) check_eq("done_cycle", 64'(cyc), 64'(NUM_WORDS * (BPW + 1) + CKS));
      end
    end
    check_eq("seq_done_seen", 64'(done_seen), 64'd1);
    start = poke;
    bvalid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("idle_busy", 64'(Busy_SO), 64'd0);
    check_eq("idle_ready", 64'(ByteReady_SO), 64'd0);
    check_eq("done_one_cycle", 64'(Done_SO), 64'd0);
    check_eq("err_hold", 64'(Err_SO), 64'(err_exp));
    repeat (3) @(posedge clk);
    #1;
    check_eq("no_restart", 64'(Busy_SO), 64'd0);
    check_eq("err_sticky", 64'(Err_SO), 64'(err_exp));
    check_eq("idle_no_wr", 64'(WrEn_SO), 64'd0);
  endtask

  initial begin
    // Reset held with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      start = 1'($urandom);
      bvalid = 1'($urandom);
      bdata = 8'($urandom);
      @(posedge clk); #1;
      check_eq("rst_outs", all_outs(), 64'd0);
    end
    start = 1'b0;
    bvalid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("post_rst_idle", 64'({Busy_SO, ByteReady_SO, WrEn_SO, Done_SO}), 64'd0);
    end

    // Ramp 0x00..0x7F, continuous, start pulses while busy.
    for (int i = 0; i < NDATA; i++) byte_mem[i] = 8'(i);
    chk_byte = 8'hC0;
    load_seq(0, 1'b1, -1, ab);

    // Same ramp with a wrong checksum byte.
    chk_byte = 8'hC1;
    load_seq(0, 1'b0, -1, ab);

    // Random bytes, valid every other cycle, correct checksum.
    for (int i = 0; i < NDATA; i++) byte_mem[i] = 8'($urandom);
    chk_byte = sum_bytes();
    load_seq(1, 1'b0, -1, ab);

    // Random bytes, random valid gaps, random checksum byte.
    for (int i = 0; i < NDATA; i++) byte_mem[i] = 8'($urandom);
    chk_byte = 8'($urandom);
    load_seq(2, 1'b0, -1, ab);

    // Reset right after the addr-10 write.
    for (int i = 0; i < NDATA; i++) byte_mem[i] = 8'(i);
    load_seq(0, 1'b0, 10, ab);
    check_eq("aborted", 64'(ab), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("abort_held_zero", all_outs(), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_release_idle", 64'(Busy_SO), 64'd0);

    // Fresh load with bytes 0xAA.. must start again at addr 0.
    for (int i = 0; i < NDATA; i++) byte_mem[i] = 8'(8'hAA + i);
    chk_byte = sum_bytes();
    load_seq(0, 1'b0, -1, ab);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
